// File: rtl/ram_sp_access_ctrl.sv
// ram_sp_access_ctrl
// Initiator-side controller for a single-port RAM whose read address is
// registered inside the RAM (read data appears one cycle after the address).
// Arbitrates between a write and a read request channel (valid/ready), drives
// the RAM pins from registers, captures read data two cycles after a read is
// accepted, and offers a hardware clear that fills every word with one value.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data   write request channel
//   rd_valid/rd_ready/rd_addr           read request channel
//   rd_data_valid/rd_data               read response (one-cycle pulse, data held)
//   clr_start/clr_value/clr_busy        whole-RAM clear control
//   ram_addr/ram_wdata/ram_we/ram_rdata RAM pin interface
module ram_sp_access_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_RD_ADDR = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_CLR     = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [2:0]        state_q, state_d;
    logic              last_was_write_q, last_was_write_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_data_valid_q, rd_data_valid_d;
    logic              clr_busy_q, clr_busy_d;

    logic idle_free;
    logic both_valid;

    // A pending clear blocks both channels for this edge, since it wins.
    // With both requests valid, the one served last is held off.
    always_comb begin
        idle_free  = (state_q == ST_IDLE) && !clr_start;
        both_valid = wr_valid && rd_valid;
        wr_ready   = idle_free && !(both_valid && last_was_write_q);
        rd_ready   = idle_free && !(both_valid && !last_was_write_q);
    end

    always_comb begin
        state_d          = state_q;
        last_was_write_d = last_was_write_q;
        ram_addr_d       = ram_addr_q;
        ram_wdata_d      = ram_wdata_q;
        ram_we_d         = 1'b0;
        rd_data_d        = rd_data_q;
        rd_data_valid_d  = 1'b0;
        clr_busy_d       = clr_busy_q;

        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    ram_addr_d  = '0;
                    ram_wdata_d = clr_value;
                    ram_we_d    = 1'b1;
                    clr_busy_d  = 1'b1;
                    state_d     = ST_CLR;
                end else if (wr_valid && wr_ready) begin
                    ram_addr_d       = wr_addr;
                    ram_wdata_d      = wr_data;
                    ram_we_d         = 1'b1;
                    last_was_write_d = 1'b1;
                    state_d          = ST_WR;
                end else if (rd_valid && rd_ready) begin
                    ram_addr_d       = rd_addr;
                    last_was_write_d = 1'b0;
                    state_d          = ST_RD_ADDR;
                end
            end
            ST_WR: begin
                // The RAM stores the word on this edge; write enable drops.
                state_d = ST_IDLE;
            end
            ST_RD_ADDR: begin
                // The RAM registers the address on this edge.
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rd_data_d       = ram_rdata;
                rd_data_valid_d = 1'b1;
                state_d         = ST_IDLE;
            end
            ST_CLR: begin
                // Stop on the last address instead of wrapping back to zero.
                if (ram_addr_q == LAST_ADDR) begin
                    clr_busy_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    ram_we_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            last_was_write_q <= 1'b0;
            ram_addr_q       <= '0;
            ram_wdata_q      <= '0;
            ram_we_q         <= 1'b0;
            rd_data_q        <= '0;
            rd_data_valid_q  <= 1'b0;
            clr_busy_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_was_write_q <= last_was_write_d;
            ram_addr_q       <= ram_addr_d;
            ram_wdata_q      <= ram_wdata_d;
            ram_we_q         <= ram_we_d;
            rd_data_q        <= rd_data_d;
            rd_data_valid_q  <= rd_data_valid_d;
            clr_busy_q       <= clr_busy_d;
        end
    end

    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign ram_we        = ram_we_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
    assign clr_busy      = clr_busy_q;

endmodule

// File: tb/tb_ram_sp_access_ctrl.sv
// tb_ram_sp_access_ctrl
// Drives ram_sp_access_ctrl attached to a behavioural 64x8 RAM with a
// registered read address, and compares every cycle against a
// transaction-level model (busy windows, alternating arbitration, a memory
// image and the expected read results).
module tb_ram_sp_access_ctrl;

    localparam int DEPTH     = 64;
    localparam int MODE_NONE = 0;
    localparam int MODE_WR   = 1;
    localparam int MODE_RD   = 2;
    localparam int MODE_CLR  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [5:0] rd_addr;
    logic       rd_data_valid;
    logic [7:0] rd_data;
    logic       clr_start;
    logic [7:0] clr_value;
    logic       clr_busy;
    logic [5:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic [7:0] ram_rdata;

    always #5 clk = ~clk;

    ram_sp_access_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rd_data_valid(rd_data_valid),
        .rd_data      (rd_data),
        .clr_start    (clr_start),
        .clr_value    (clr_value),
        .clr_busy     (clr_busy),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata)
    );

    // RAM being controlled: write on the edge, read address registered.
    bit   [7:0] ram_mem [DEPTH];
    logic [5:0] ram_areg = '0;
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_areg <= ram_addr;
    end
    assign ram_rdata = ram_mem[ram_areg];

    // Reference model state
    bit   [7:0] mem_m [DEPTH];
    int         busy_m;
    int         mode_m;
    int         k_m;
    bit         last_w_m;
    bit   [7:0] rd_exp_m;
    bit   [7:0] rd_hold_m;
    bit   [5:0] addr_m;
    bit   [7:0] wdata_m;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        busy_m    = 0;
        mode_m    = MODE_NONE;
        k_m       = 0;
        last_w_m  = 1'b0;
        rd_hold_m = '0;
        addr_m    = '0;
        wdata_m   = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".ram_we"},        32'(ram_we), 0);
        check_val({tag, ".ram_addr"},      32'(ram_addr), 0);
        check_val({tag, ".ram_wdata"},     32'(ram_wdata), 0);
        check_val({tag, ".rd_data"},       32'(rd_data), 0);
        check_val({tag, ".rd_data_valid"}, 32'(rd_data_valid), 0);
        check_val({tag, ".clr_busy"},      32'(clr_busy), 0);
    endtask

    // One clock cycle: drive at the falling edge, check readiness, then check
    // the registered outputs just after the rising edge.
    task automatic step(input bit wv, input bit [5:0] wa, input bit [7:0] wd,
                        input bit rv, input bit [5:0] ra,
                        input bit cs, input bit [7:0] cv);
        bit free, both, exp_wr, exp_rd, exp_rdv, exp_we;
        @(negedge clk);
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        rd_valid  = rv;
        rd_addr   = ra;
        clr_start = cs;
        clr_value = cv;
        #1;
        free   = (busy_m == 0) && !cs;
        both   = wv && rv;
        exp_wr = free && !(both && last_w_m);
        exp_rd = free && !(both && !last_w_m);
        check_val("wr_ready", 32'(wr_ready), 32'(exp_wr));
        check_val("rd_ready", 32'(rd_ready), 32'(exp_rd));
        @(posedge clk);
        #1;
        exp_rdv = 1'b0;
        exp_we  = 1'b0;
        if (busy_m > 0) begin
            busy_m--;
            k_m++;
            if (mode_m == MODE_RD && busy_m == 0) begin
                exp_rdv   = 1'b1;
                rd_hold_m = rd_exp_m;
            end
            if (mode_m == MODE_CLR && busy_m > 0) begin
                exp_we = 1'b1;
                addr_m = k_m[5:0];
            end
            if (busy_m == 0) mode_m = MODE_NONE;
        end else if (cs) begin
            mode_m  = MODE_CLR;
            busy_m  = DEPTH;
            k_m     = 0;
            addr_m  = '0;
            wdata_m = cv;
            exp_we  = 1'b1;
            foreach (mem_m[i]) mem_m[i] = cv;
        end else if (wv && exp_wr) begin
            mode_m     = MODE_WR;
            busy_m     = 1;
            addr_m     = wa;
            wdata_m    = wd;
            mem_m[wa]  = wd;
            last_w_m   = 1'b1;
            exp_we     = 1'b1;
        end else if (rv && exp_rd) begin
            mode_m   = MODE_RD;
            busy_m   = 2;
            addr_m   = ra;
            rd_exp_m = mem_m[ra];
            last_w_m = 1'b0;
        end
        check_val("rd_data_valid", 32'(rd_data_valid), 32'(exp_rdv));
        check_val("rd_data",       32'(rd_data),       32'(rd_hold_m));
        check_val("ram_we",        32'(ram_we),        32'(exp_we));
        check_val("ram_addr",      32'(ram_addr),      32'(addr_m));
        check_val("ram_wdata",     32'(ram_wdata),     32'(wdata_m));
        check_val("clr_busy",      32'(clr_busy),      (mode_m == MODE_CLR) ? 1 : 0);
        $display("cyc t=%0t wv=%0b rv=%0b cs=%0b we=%0b addr=%0h rdv=%0b rd=%0h busy=%0b",
                 $time, wv, rv, cs, ram_we, ram_addr, rd_data_valid, rd_data, clr_busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0, 8'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        clr_start = 1'b0;
        rst       = 1'b0;
        model_reset();
    endtask

    initial begin
        // 1: reset with random inputs
        rst       = 1'b1;
        wr_valid  = 1'($urandom);
        wr_addr   = 6'($urandom);
        wr_data   = 8'($urandom);
        rd_valid  = 1'($urandom);
        rd_addr   = 6'($urandom);
        clr_start = 1'($urandom);
        clr_value = 8'($urandom);
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset_outputs("reset");
        end
        @(negedge clk);
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        clr_start = 1'b0;
        rst       = 1'b0;
        #1;
        check_val("reset.wr_ready", 32'(wr_ready), 1);
        check_val("reset.rd_ready", 32'(rd_ready), 1);

        // 2: write then read back
        step(1, 6'h03, 8'h5A, 0, '0, 0, 8'h00);
        idle(1);
        step(0, '0, '0, 1, 6'h03, 0, 8'h00);
        idle(4);

        // 3: contention from reset, alternating W,R,W,R
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 6'h10, 8'h11, 1, 6'h10, 0, 8'h00);
        idle(3);

        // 4: clear wins over a write, clr_value changes ignored
        step(1, 6'h20, 8'hA5, 0, '0, 1, 8'hFF);
        for (int i = 0; i < DEPTH + 1; i++) step(1, 6'h20, 8'hA5, 0, '0, 0, 8'($urandom));
        idle(1);
        step(0, '0, '0, 1, 6'h3F, 0, 8'h00);
        idle(2);
        step(0, '0, '0, 1, 6'h00, 0, 8'h00);
        idle(2);

        // 6: clr_start during a write is ignored
        step(1, 6'h07, 8'h77, 0, '0, 0, 8'h00);
        step(0, '0, '0, 0, '0, 1, 8'h33);
        idle(3);
        step(0, '0, '0, 1, 6'h07, 0, 8'h00);
        idle(3);

        // 5: reset in the middle of a read
        step(0, '0, '0, 1, 6'h3F, 0, 8'h00);
        #2;
        rst       = 1'b1;
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        clr_start = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_val("rst_hold.rd_data_valid", 32'(rd_data_valid), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom), 6'($urandom), 8'($urandom),
                 1'($urandom), 6'($urandom),
                 ($urandom_range(0, 40) == 0), 8'($urandom));
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_sp_access_ctrl.md
Name: ram_sp_access_ctrl

Overview:
- Initiator-side controller for the 64x8 single-port RAM with a registered read address.
- Accepts write and read requests over valid/ready handshakes and arbitrates between them.
- Drives the RAM's address, write-data and write-enable pins, and captures read data at the correct cycle.
- Also provides a hardware clear sequence that fills the whole RAM with one value. It sits between client logic and the RAM instance.

Parameters:
DATA_W, 8, data width of RAM word and client data
ADDR_W, 6, address width; RAM depth is 2**ADDR_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
wr_valid  input  1  write request valid
wr_ready  output  1  write request accepted when wr_valid&wr_ready at a rising edge
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_valid  input  1  read request valid
rd_ready  output  1  read request accepted when rd_valid&rd_ready at a rising edge
rd_addr  input  ADDR_W  read address
rd_data_valid  output  1  one-cycle pulse; rd_data is valid
rd_data  output  DATA_W  captured read data, held until next capture
clr_start  input  1  start clear of entire RAM
clr_value  input  DATA_W  fill value, sampled at clear start
clr_busy  output  1  clear in progress
ram_addr  output  ADDR_W  to RAM address pin (registered)
ram_wdata  output  DATA_W  to RAM data-in pin (registered)
ram_we  output  1  to RAM write enable (registered)
ram_rdata  input  DATA_W  from RAM data-out pin

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - FSM in IDLE.
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - rd_data=0, rd_data_valid=0, clr_busy=0.
  - Arbitration flag last_was_write=0, so write is favoured first.
- FSM states: IDLE, WR, RD_ADDR, RD_DATA, CLR.
- Ready signals:
  - wr_ready and rd_ready are combinational.
  - Both are asserted only when state==IDLE and clr_start==0.
  - When both requests are valid, only the arbitration winner sees its ready high.
- Arbitration in IDLE, decided at each edge:
  - clr_start has highest priority.
  - Otherwise, if only one request is valid, serve it.
  - If both are valid, serve the one not served last: write if last_was_write==0, else read. Update last_was_write on every accepted request.
- Write, accepted at edge N:
  - Edge N: ram_addr<=wr_addr, ram_wdata<=wr_data, ram_we<=1, go to WR.
  - Edge N+1: the RAM stores the word; ram_we<=0, go to IDLE.
  - ram_we is high for exactly one cycle. Throughput is one write per 2 cycles.
- Read, accepted at edge N:
  - Edge N: ram_addr<=rd_addr, ram_we<=0, go to RD_ADDR.
  - Edge N+1: the RAM registers the address; go to RD_DATA.
  - Edge N+2: rd_data<=ram_rdata, rd_data_valid<=1, go to IDLE.
  - Latency is 2 cycles from acceptance to rd_data_valid. rd_data_valid is high for exactly one cycle.
  - Throughput is one read per 3 cycles.
- Read-after-write to the same address returns the new data, because the write completes before the read address is registered.
- Clear, started at edge N with clr_start=1 in IDLE:
  - Edge N: ram_addr<=0, ram_wdata<=clr_value, ram_we<=1, clr_busy<=1, go to CLR.
  - Each following edge in CLR:
    - If ram_addr==2**ADDR_W-1: ram_we<=0, clr_busy<=0, go to IDLE.
    - Else: ram_addr<=ram_addr+1.
  - Exactly 2**ADDR_W write cycles (64 at default). ram_addr never wraps past the last address.
  - clr_value changes during CLR are ignored.
- clr_start outside IDLE is ignored; it is not queued.
- Outside WR/CLR, ram_we is 0. ram_addr and ram_wdata hold their last values.
- rd_data is updated only in the RD_DATA→IDLE transition.
- Reset mid-operation:
  - All registers return to reset values immediately.
  - An in-flight read produces no rd_data_valid.
  - An aborted clear leaves RAM partially filled; this is not an error.
  - Requests pending at reset are dropped and must be re-presented by the client.

Test Plan:
1. Reset: assert rst with random inputs -> ram_we=0, ram_addr=0, rd_data_valid=0, clr_busy=0, wr_ready=rd_ready=1 after release with clr_start=0.
2. Write/read: write 0x5A to 0x03, then read 0x03 -> ram_we high exactly 1 cycle; rd_data_valid pulses 2 cycles after read acceptance with rd_data=0x5A; rd_data holds 0x5A afterward.
3. Contention: hold wr_valid (0x11→0x10) and rd_valid (0x10) together from reset -> write served first, read served second, rd_data=0x11. Two more contending pairs alternate W,R,W,R.
4. Clear: clr_value=0xFF, pulse clr_start with wr_valid also high -> clear wins; clr_busy high 64 cycles; ram_addr steps 0..63; wr_ready low throughout. Then read 0x3F and 0x00 -> both 0xFF.
5. Reset mid-read: assert rst while in RD_ADDR -> no rd_data_valid pulse; all outputs at reset values asynchronously, without waiting for a clock edge.
6. clr_start while busy: pulse clr_start during an active write -> ignored; no clr_busy, write completes normally.
